// File: rtl/pipe_share_arbiter.sv
// Round-robin front end for a shared fixed-latency pipeline. A shadow tag shift
// register, aligned with the pipeline latency, routes each result back to its requester.
module pipe_share_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 3
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_enable,
    input  logic [N_REQ-1:0]        i_req_valid,
    input  logic [N_REQ*DATA_W-1:0] i_req_data,
    output logic [N_REQ-1:0]        o_req_ready,
    output logic                    o_pipe_in_valid,
    output logic [DATA_W-1:0]       o_pipe_in_data,
    input  logic                    i_pipe_out_valid,
    input  logic [DATA_W-1:0]       i_pipe_out_data,
    output logic [N_REQ-1:0]        o_resp_valid,
    output logic [DATA_W-1:0]       o_resp_data,
    output logic                    o_idle,
    output logic                    o_err_orphan
);

    localparam int TAG_W = $clog2(N_REQ);

    logic [TAG_W-1:0]  r_ptr;
    logic              r_in_valid;
    logic [DATA_W-1:0] r_in_data;
    logic [TAG_W-1:0]  r_in_tag;
    logic [LATENCY-1:0] r_tag_v;
    logic [TAG_W-1:0]  r_tag [LATENCY];
    logic              r_err;

    logic              w_found;
    logic              w_grant;
    logic [TAG_W-1:0]  w_grant_idx;
    logic [TAG_W-1:0]  w_ptr_next;
    int                w_j;
    logic              w_last_v;
    logic [TAG_W-1:0]  w_last_tag;

    // First valid requester at or after the pointer, wrapping modulo N_REQ.
    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = '0;
        w_j         = 0;
        for (int k = 0; k < N_REQ; k++) begin
            w_j = (int'(r_ptr) + k) % N_REQ;
            if (!w_found && i_req_valid[w_j]) begin
                w_found     = 1'b1;
                w_grant_idx = TAG_W'(w_j);
            end
        end
        w_grant = i_rst && i_enable && w_found;
    end

    assign w_ptr_next  = (w_grant_idx == TAG_W'(N_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
    assign o_req_ready = w_grant ? (N_REQ'(1) << w_grant_idx) : '0;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_ptr      <= '0;
            r_in_valid <= 1'b0;
            r_in_data  <= '0;
            r_in_tag   <= '0;
        end else begin
            r_in_valid <= w_grant;
            if (w_grant) begin
                r_ptr     <= w_ptr_next;
                r_in_data <= i_req_data[int'(w_grant_idx)*DATA_W +: DATA_W];
                r_in_tag  <= w_grant_idx;
            end
        end
    end

    // Tag shadow shifts every cycle; the pipeline never stalls.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_tag_v <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                r_tag[k] <= '0;
            end
        end else begin
            r_tag_v[0] <= r_in_valid;
            r_tag[0]   <= r_in_tag;
            for (int k = 1; k < LATENCY; k++) begin
                r_tag_v[k] <= r_tag_v[k-1];
                r_tag[k]   <= r_tag[k-1];
            end
        end
    end

    assign w_last_v   = r_tag_v[LATENCY-1];
    assign w_last_tag = r_tag[LATENCY-1];

    // Any disagreement between the shadow and the pipeline is a lost or orphan result.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_err <= 1'b0;
        end else if (i_pipe_out_valid != w_last_v) begin
            r_err <= 1'b1;
        end
    end

    assign o_resp_valid    = (i_rst && w_last_v && i_pipe_out_valid) ? (N_REQ'(1) << w_last_tag) : '0;
    assign o_resp_data     = i_pipe_out_data;
    assign o_pipe_in_valid = r_in_valid;
    assign o_pipe_in_data  = r_in_data;
    assign o_idle          = !r_in_valid && !(|r_tag_v);
    assign o_err_orphan    = r_err;

endmodule

// File: tb/tb_pipe_share_arbiter.sv
// Bench for pipe_share_arbiter: directed scenarios then random traffic, checked against
// a transaction-level model (grant search plus a queue of due responses).
module tb_pipe_share_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int L  = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            enable;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            pipe_in_valid;
    logic [DW-1:0]   pipe_in_data;
    logic            pipe_out_valid;
    logic [DW-1:0]   pipe_out_data;
    logic [N-1:0]    resp_valid;
    logic [DW-1:0]   resp_data;
    logic            idle;
    logic            err_orphan;
    logic            inj;

    always #5 clk = ~clk;

    pipe_share_arbiter #(.N_REQ(N), .DATA_W(DW), .LATENCY(L)) dut (
        .i_clk(clk), .i_rst(rst), .i_enable(enable),
        .i_req_valid(req_valid), .i_req_data(req_data), .o_req_ready(req_ready),
        .o_pipe_in_valid(pipe_in_valid), .o_pipe_in_data(pipe_in_data),
        .i_pipe_out_valid(pipe_out_valid), .i_pipe_out_data(pipe_out_data),
        .o_resp_valid(resp_valid), .o_resp_data(resp_data),
        .o_idle(idle), .o_err_orphan(err_orphan)
    );

    // Stand-in pipeline: L cycles, output is the inverted input; reset with the DUT.
    logic [L-1:0]  pv;
    logic [DW-1:0] pd [L];
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pv <= '0;
            for (int k = 0; k < L; k++) pd[k] <= '0;
        end else begin
            pv[0] <= pipe_in_valid;
            pd[0] <= pipe_in_data;
            for (int k = 1; k < L; k++) begin
                pv[k] <= pv[k-1];
                pd[k] <= pd[k-1];
            end
        end
    end
    assign pipe_out_valid = pv[L-1] | inj;
    assign pipe_out_data  = ~pd[L-1];

    typedef struct {
        int          due;
        int          idx;
        logic [31:0] data;
    } rsp_t;

    rsp_t        q[$];
    int          m_ptr;
    bit          m_iv;
    logic [31:0] m_id;
    bit          m_err;
    int          cyc;
    int          n_checks;
    int          n_errors;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called in the low phase with inputs already applied; checks, advances model, clocks.
    task automatic cycle();
        logic [N-1:0]  exp_rdy;
        logic [N-1:0]  exp_rv;
        logic [DW-1:0] exp_rd;
        int            g;
        #1;
        g = -1;
        if (enable) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (g < 0 && req_valid[j]) g = j;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        exp_rv = '0;
        exp_rd = '0;
        if (q.size() > 0 && q[0].due == cyc) begin
            exp_rv[q[0].idx] = 1'b1;
            exp_rd = ~q[0].data;
        end
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        chk("resp_valid", 64'(resp_valid), 64'(exp_rv));
        if (exp_rv != '0) chk("resp_data", 64'(resp_data), 64'(exp_rd));
        chk("pipe_in_valid", 64'(pipe_in_valid), 64'(m_iv));
        chk("pipe_in_data", 64'(pipe_in_data), 64'(m_id));
        chk("idle", 64'(idle), 64'(q.size() == 0));
        chk("err_orphan", 64'(err_orphan), 64'(m_err));
        if (exp_rv != '0) void'(q.pop_front());
        if (inj && exp_rv == '0) m_err = 1'b1;
        if (g >= 0) begin
            q.push_back('{cyc + 1 + L, g, req_data[g*DW +: DW]});
            m_ptr = (g + 1) % N;
            m_iv  = 1'b1;
            m_id  = req_data[g*DW +: DW];
        end else begin
            m_iv = 1'b0;
        end
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = $urandom;
    endtask

    task automatic reset_pulse();
        #2 rst = 1'b0;
        #1;
        chk("rst_pipe_in_valid", 64'(pipe_in_valid), 64'd0);
        chk("rst_idle", 64'(idle), 64'd1);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_err_orphan", 64'(err_orphan), 64'd0);
        q.delete();
        m_ptr = 0;
        m_iv  = 1'b0;
        m_id  = '0;
        m_err = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        rst = 1'b1;
    endtask

    initial begin
        n_checks = 0; n_errors = 0; cyc = 0;
        m_ptr = 0; m_iv = 1'b0; m_id = '0; m_err = 1'b0;
        rst = 1'b0; enable = 1'b1; req_valid = '1; req_data = '0; inj = 1'b0;
        @(negedge clk);
        #1;
        chk("reset_req_ready", 64'(req_ready), 64'd0);
        chk("reset_idle", 64'(idle), 64'd1);
        chk("reset_pipe_in_valid", 64'(pipe_in_valid), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        req_valid = '0;
        for (int i = 0; i < 3; i++) cycle();

        // single request from requester 2
        req_valid = 4'b0100;
        req_data[2*DW +: DW] = 32'h10;
        cycle();
        req_valid = '0;
        for (int i = 0; i < 6; i++) cycle();

        // bring the pointer back to 0, then full contention
        req_valid = 4'b1000;
        cycle();
        req_valid = '0;
        cycle();
        req_valid = '1;
        for (int i = 0; i < 6; i++) begin
            rand_data();
            cycle();
        end
        req_valid = '0;
        for (int i = 0; i < L + 3; i++) cycle();

        // fairness between requesters 1 and 3
        req_valid = 4'b1010;
        for (int i = 0; i < 8; i++) begin
            rand_data();
            cycle();
        end
        req_valid = '0;
        for (int i = 0; i < L + 3; i++) cycle();

        // drain with requests still pending
        req_valid = '1;
        for (int i = 0; i < 3; i++) begin
            rand_data();
            cycle();
        end
        enable = 1'b0;
        for (int i = 0; i < L + 4; i++) cycle();
        enable = 1'b1;
        req_valid = '0;
        cycle();

        // asynchronous reset with two items in flight
        req_valid = '1;
        for (int i = 0; i < 2; i++) begin
            rand_data();
            cycle();
        end
        req_valid = '0;
        reset_pulse();
        for (int i = 0; i < L + 3; i++) cycle();
        req_valid = '1;
        rand_data();
        cycle();
        req_valid = '0;
        for (int i = 0; i < L + 3; i++) cycle();

        // orphan result injected with an empty tag register
        inj = 1'b1;
        cycle();
        inj = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        reset_pulse();
        for (int i = 0; i < 2; i++) cycle();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            enable    = ($urandom_range(0, 7) != 0);
            req_valid = N'($urandom);
            rand_data();
            cycle();
        end
        enable = 1'b1;
        req_valid = '0;
        for (int i = 0; i < L + 3; i++) cycle();
        chk("final_queue_empty", 64'(q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_share_arbiter.md
Name: pipe_share_arbiter

Overview:
Shares one fixed-latency, valid-only stitched pipeline (no backpressure, one issue per cycle) among N_REQ requesters. Round-robin arbitration selects one request per cycle and registers it into the pipeline input. A requester tag travels through a shadow shift register aligned with pipeline latency, so each pipeline output is routed back to the requester that issued it. Sits directly in front of and behind the generated pipeline wrapper.

Parameters:
N_REQ, 4, number of requesters (>=2)
DATA_W, 32, payload width in and out of the pipeline
LATENCY, 3, cycles from pipeline in_valid to out_valid (generated wrapper with input and output flops: 3)
TAG_W, $clog2(N_REQ), derived; width of routing tag

Ports:
clk  in  1  clock, all logic posedge
rst  in  1  asynchronous, active-low reset
enable  in  1  1 = grants allowed; 0 = drain, no new grants
req_valid  in  N_REQ  per-requester request valid
req_data  in  N_REQ*DATA_W  per-requester payload, requester i at [i*DATA_W +: DATA_W]
req_ready  out  N_REQ  one-hot grant; transfer when req_valid[i] & req_ready[i]
pipe_in_valid  out  1  to pipeline in_valid, registered
pipe_in_data  out  DATA_W  to pipeline data input, registered
pipe_out_valid  in  1  from pipeline out_valid
pipe_out_data  in  DATA_W  from pipeline out
resp_valid  out  N_REQ  one-hot response strobe
resp_data  out  DATA_W  response payload, shared by all requesters
idle  out  1  no request in issue register or tag shift register
err_orphan  out  1  sticky: pipe_out_valid seen with no matching tag

Behaviour:
- Reset (rst=0, async): pipe_in_valid=0, pipe_in_data=0, rr pointer=0, all tag-valid bits=0, err_orphan=0. req_ready=0 and resp_valid=0 while in reset. idle=1.
- Arbitration (combinational): if enable=1, grant the first i with req_valid[i]=1, searching from ptr upward with wrap modulo N_REQ. req_ready is one-hot or zero; it never asserts for a requester with req_valid=0. No request or enable=0 -> req_ready=0.
- Pointer: on a transfer by requester g, ptr <= (g+1) mod N_REQ. Otherwise ptr holds.
- Issue register: each cycle, pipe_in_valid <= transfer; on transfer, pipe_in_data <= req_data[g]. Otherwise data holds. Max issue rate is one per cycle; requests are never dropped, only deferred.
- Tag shift register: LATENCY entries of {valid, tag}. Entry 0 loads {pipe_in_valid, tag of issue register}. Each entry shifts every cycle unconditionally; the pipeline has no stall.
- Response: the last entry is aligned with pipe_out_valid. If pipe_out_valid=1 and tag valid=1: resp_valid[tag]=1 (one-hot) and resp_data=pipe_out_data, combinational, same cycle. If pipe_out_valid=1 and tag valid=0: resp_valid stays 0 and err_orphan is set until reset. If tag valid=1 and pipe_out_valid=0: also sets err_orphan (lost result).
- End-to-end latency: accept at cycle t -> pipe_in_valid at t+1 -> resp_valid at t+1+LATENCY (t+4 by default).
- Drain: enable 1->0 blocks new grants the same cycle. In-flight items complete normally. idle rises the cycle after the last tag leaves.
- Reset mid-operation: in-flight tags are discarded. The integrator holds the pipeline rst high (active) whenever this block's rst is low, so no orphan outputs follow reset. err_orphan is a bench check for this requirement.
- Simultaneous events: a grant and a response to the same requester in the same cycle are independent and both occur.
- Widths: no arithmetic on data; the tag equals the granted index zero-extended to TAG_W.

Test Plan:
- Single request: req_valid[2]=1, data 0x10 at cycle 5 -> req_ready[2]=1 at cycle 5, pipe_in_valid=1 at cycle 6, resp_valid=4'b0100 at cycle 9 with resp_data equal to pipeline output for 0x10.
- Contention: all four req_valid held high, ptr=0 -> grants 0,1,2,3,0,1 on consecutive cycles; responses return in the same order, one per cycle, each to the correct requester.
- Fairness: req 1 and req 3 continuously valid -> grants alternate 1,3,1,3; neither starves.
- Drain: 3 items in flight, enable dropped -> req_ready=0 immediately, the 3 responses still delivered, idle=1 one cycle after the last resp_valid.
- Async reset mid-flight: rst pulsed low between clock edges with 2 items in flight -> pipe_in_valid and tag valids clear without a clock edge, no resp_valid after release, err_orphan=0, ptr=0.
- Orphan injection: force pipe_out_valid=1 with an empty tag register -> resp_valid=0, err_orphan=1 and held until reset.
